// File: rtl/ff_frame_packer.sv
// Serial-to-frame packer: accumulates IN_W-bit beats into PAYLOAD_BITS frames tagged with an ID,
// buffered in an NBUF-deep ring. Define FRAMEID_COUNT_EN to source IDs from an internal counter.
module ff_frame_packer #(
    parameter int unsigned IN_W         = 1,
    parameter int unsigned PAYLOAD_BITS = 625,
    parameter int unsigned NBUF         = 2,
    parameter int unsigned ID_W         = 24
) (
    input  logic                           ff_clk,
    input  logic                           reset,
    input  logic                           ff_en,
    input  logic                           start,
    input  logic [IN_W-1:0]                ff_data,
    input  logic [ID_W-1:0]                frameid_in,
    input  logic                           rd_ack,
    output logic                           rd_valid,
    output logic [ID_W+PAYLOAD_BITS-1:0]   rd_data,
    output logic [2:0]                     fill_level,
    output logic                           overflow,
    output logic                           busy
);

    localparam int unsigned FRAME_W = ID_W + PAYLOAD_BITS;
    localparam int unsigned CNT_W   = $clog2(PAYLOAD_BITS + 1);
    localparam int unsigned PTR_W   = (NBUF > 2) ? 2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BITS - IN_W);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NBUF - 1);
    localparam logic [2:0]       FILL_MAX = 3'(NBUF);

    logic [PAYLOAD_BITS-1:0]      acc_payload;
    logic [ID_W-1:0]              acc_id;
    logic [CNT_W-1:0]             bit_cnt;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [FRAME_W-1:0]           mem [NBUF];

    logic                         beat_c;
    logic [PAYLOAD_BITS+IN_W-1:0] shift_c;
    logic [PAYLOAD_BITS-1:0]      acc_next_c;
    logic                         frame_done_c;
    logic [ID_W-1:0]              id_src_c;
    logic [ID_W-1:0]              frame_id_c;
    logic [FRAME_W-1:0]           wr_frame_c;
    logic                         pop_c;
    logic                         full_c;
    logic                         push_c;
    logic                         drop_c;
    logic [2:0]                   fill_next_c;
    logic [PTR_W-1:0]             rd_ptr_next_c;
    logic [PTR_W-1:0]             wr_ptr_next_c;
    logic [CNT_W-1:0]             bit_cnt_next_c;
    logic [FRAME_W-1:0]           rd_data_next_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef FRAMEID_COUNT_EN
    logic [ID_W-1:0] id_cnt;
    logic            unused_frameid;

    assign unused_frameid = ^frameid_in;
    assign id_src_c       = id_cnt;

    // Advances on every completed frame, dropped ones included
    always_ff @(posedge ff_clk) begin
        if (reset) begin
            id_cnt <= '0;
        end else if (frame_done_c) begin
            id_cnt <= id_cnt + ID_W'(1);
        end
    end
`else
    assign id_src_c = frameid_in;
`endif

    // Beat decode, frame completion and ring bookkeeping
    always_comb begin
        beat_c         = ff_en & start;
        shift_c        = {ff_data, acc_payload};
        acc_next_c     = shift_c[PAYLOAD_BITS+IN_W-1:IN_W];
        frame_done_c   = beat_c && (bit_cnt == CNT_LAST);
        frame_id_c     = (bit_cnt == '0) ? id_src_c : acc_id;
        wr_frame_c     = {acc_next_c, frame_id_c};
        pop_c          = rd_ack && (fill_level != 3'd0);
        full_c         = (fill_level == FILL_MAX);
        push_c         = frame_done_c && (!full_c || pop_c);
        drop_c         = frame_done_c && full_c && !pop_c;

        fill_next_c    = fill_level;
        if (push_c && !pop_c) begin
            fill_next_c = fill_level + 3'd1;
        end else if (pop_c && !push_c) begin
            fill_next_c = fill_level - 3'd1;
        end

        rd_ptr_next_c  = pop_c  ? ptr_inc(rd_ptr) : rd_ptr;
        wr_ptr_next_c  = push_c ? ptr_inc(wr_ptr) : wr_ptr;

        bit_cnt_next_c = bit_cnt;
        if (beat_c) begin
            bit_cnt_next_c = frame_done_c ? '0 : bit_cnt + CNT_W'(IN_W);
        end

        // New head of the ring may be the frame being written this cycle
        if (push_c && (wr_ptr == rd_ptr_next_c)) begin
            rd_data_next_c = wr_frame_c;
        end else begin
            rd_data_next_c = mem[rd_ptr_next_c];
        end
    end

    // Control state and registered outputs
    always_ff @(posedge ff_clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= 3'd0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            rd_data    <= '0;
        end else begin
            bit_cnt    <= bit_cnt_next_c;
            wr_ptr     <= wr_ptr_next_c;
            rd_ptr     <= rd_ptr_next_c;
            fill_level <= fill_next_c;
            rd_valid   <= (fill_next_c != 3'd0);
            busy       <= (bit_cnt_next_c != '0);
            if (drop_c) begin
                overflow <= 1'b1;
            end
            if (fill_next_c != 3'd0) begin
                rd_data <= rd_data_next_c;
            end
        end
    end

    // Datapath storage; validity is tracked by the pointers and fill level
    always_ff @(posedge ff_clk) begin
        if (beat_c) begin
            acc_payload <= acc_next_c;
            if (bit_cnt == '0) begin
                acc_id <= id_src_c;
            end
        end
        if (push_c && !reset) begin
            mem[wr_ptr] <= wr_frame_c;
        end
    end

endmodule

// File: tb/tb_ff_frame_packer.sv
// Directed self-checking bench for ff_frame_packer (IN_W=1, PAYLOAD_BITS=8, NBUF=2, ID_W=8),
// plus a nibble-wide instance for the external frame-ID path.
module tb_ff_frame_packer;

    logic        ff_clk = 1'b0;
    logic        reset;
    logic        ff_en;
    logic        start;
    logic [0:0]  ff_data;
    logic [7:0]  frameid_in;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  fill_level;
    logic        overflow;
    logic        busy;

    logic        ff_en_b;
    logic        start_b;
    logic [3:0]  ff_data_b;
    logic [7:0]  frameid_b;
    logic        rd_ack_b;
    logic        rd_valid_b;
    logic [15:0] rd_data_b;
    logic [2:0]  fill_level_b;
    logic        overflow_b;
    logic        busy_b;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  id_model;
    logic [7:0]  id_exp_b;

    always #5 ff_clk = ~ff_clk;

    ff_frame_packer #(.IN_W(1), .PAYLOAD_BITS(8), .NBUF(2), .ID_W(8)) u_dut (
        .ff_clk(ff_clk), .reset(reset), .ff_en(ff_en), .start(start), .ff_data(ff_data),
        .frameid_in(frameid_in), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .fill_level(fill_level), .overflow(overflow), .busy(busy)
    );

    ff_frame_packer #(.IN_W(4), .PAYLOAD_BITS(8), .NBUF(2), .ID_W(8)) u_dut_b (
        .ff_clk(ff_clk), .reset(reset), .ff_en(ff_en_b), .start(start_b), .ff_data(ff_data_b),
        .frameid_in(frameid_b), .rd_ack(rd_ack_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
        .fill_level(fill_level_b), .overflow(overflow_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ff_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] pl, input logic ack_last);
        for (int i = 0; i < 8; i++) begin
            ff_en   = 1'b1;
            start   = 1'b1;
            ff_data = pl[i];
            rd_ack  = ack_last && (i == 7);
            tick();
        end
        ff_en      = 1'b0;
        start      = 1'b0;
        rd_ack     = 1'b0;
        id_model   = id_model + 8'd1;
        frameid_in = id_model;
    endtask

    task automatic pop();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_fill"}, 64'(fill_level), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    endtask

    initial begin
        logic [7:0] split_pl;
        reset = 1'b1; ff_en = 1'b0; start = 1'b0; ff_data = 1'b0; rd_ack = 1'b0;
        ff_en_b = 1'b0; start_b = 1'b0; ff_data_b = 4'h0; frameid_b = 8'h00; rd_ack_b = 1'b0;
        id_model = 8'h00; frameid_in = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("rst");

        // Single frame, bits 1,0,1,1,0,0,1,0
        ff_en = 1'b1; start = 1'b1; ff_data = 1'b1;
        tick();
        ff_en = 1'b0; start = 1'b0;
        check("busy_first_beat", 64'(busy), 64'd1);
        check("valid_first_beat", 64'(rd_valid), 64'd0);
        ff_en = 1'b1; start = 1'b1;
        for (int i = 1; i < 8; i++) begin
            split_pl = 8'h4D;
            ff_data = split_pl[i];
            tick();
        end
        ff_en = 1'b0; start = 1'b0;
        id_model = 8'd1; frameid_in = id_model;
        check("f0_valid", 64'(rd_valid), 64'd1);
        check("f0_data", 64'(rd_data), 64'h4D00);
        check("f0_fill", 64'(fill_level), 64'd1);
        check("f0_busy", 64'(busy), 64'd0);

        // Fill, then drop a third frame
        send_frame(8'h3C, 1'b0);
        check("f1_fill", 64'(fill_level), 64'd2);
        check("f1_ovf", 64'(overflow), 64'd0);
        check("f1_head", 64'(rd_data), 64'h4D00);
        send_frame(8'hFF, 1'b0);
        check("drop_ovf", 64'(overflow), 64'd1);
        check("drop_fill", 64'(fill_level), 64'd2);
        check("drop_head", 64'(rd_data), 64'h4D00);
        pop();
        check("pop1_data", 64'(rd_data), 64'h3C01);
        check("pop1_fill", 64'(fill_level), 64'd1);
        pop();
        check("pop2_valid", 64'(rd_valid), 64'd0);
        check("pop2_fill", 64'(fill_level), 64'd0);
        send_frame(8'h11, 1'b0);
        check("after_drop_data", 64'(rd_data), 64'h1103);
        check("ovf_sticky", 64'(overflow), 64'd1);
        pop();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        id_model = 8'h00; frameid_in = id_model;
        check("rst2_ovf", 64'(overflow), 64'd0);

        // Completion and pop in the same cycle while full
        send_frame(8'hA1, 1'b0);
        send_frame(8'hB2, 1'b0);
        send_frame(8'hC3, 1'b1);
        check("full_ack_ovf", 64'(overflow), 64'd0);
        check("full_ack_fill", 64'(fill_level), 64'd2);
        check("full_ack_head", 64'(rd_data), 64'hB201);
        pop();
        check("full_ack_next", 64'(rd_data), 64'hC302);
        pop();
        check("full_ack_empty", 64'(fill_level), 64'd0);

        // Completion and pop in the same cycle while partially filled
        send_frame(8'hD4, 1'b0);
        send_frame(8'hE5, 1'b1);
        check("part_ack_fill", 64'(fill_level), 64'd1);
        check("part_ack_head", 64'(rd_data), 64'hE504);
        pop();

        // Partial frame held across start=0 pulses
        split_pl = 8'h96;
        for (int i = 0; i < 4; i++) begin
            ff_en = 1'b1; start = 1'b1; ff_data = split_pl[i];
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            ff_en = 1'b1; start = 1'b0; ff_data = 1'(i);
            tick();
        end
        check("gap_busy", 64'(busy), 64'd1);
        check("gap_valid", 64'(rd_valid), 64'd0);
        ff_en = 1'b0;
        tick();
        tick();
        for (int i = 4; i < 8; i++) begin
            ff_en = 1'b1; start = 1'b1; ff_data = split_pl[i];
            tick();
        end
        ff_en = 1'b0; start = 1'b0;
        id_model = id_model + 8'd1; frameid_in = id_model;
        check("gap_data", 64'(rd_data), 64'h9605);
        check("gap_fill", 64'(fill_level), 64'd1);
        pop();

        // Reset mid-frame with a buffered frame, beat and pop asserted
        send_frame(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ff_en = 1'b1; start = 1'b1; ff_data = 1'b1;
            tick();
        end
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_head", 64'(rd_data), 64'h5A06);
        reset = 1'b1; rd_ack = 1'b1;
        tick();
        reset = 1'b0; rd_ack = 1'b0; ff_en = 1'b0; start = 1'b0;
        id_model = 8'h00; frameid_in = id_model;
        check_reset_state("rst3");
        send_frame(8'h77, 1'b0);
        check("post_rst_data", 64'(rd_data), 64'h7700);
        check("post_rst_fill", 64'(fill_level), 64'd1);

        // Nibble-wide instance: ID sampled on the first beat
`ifdef FRAMEID_COUNT_EN
        id_exp_b = 8'h00;
`else
        id_exp_b = 8'hA5;
`endif
        frameid_b = 8'hA5; ff_en_b = 1'b1; start_b = 1'b1; ff_data_b = 4'h3;
        tick();
        check("b_busy", 64'(busy_b), 64'd1);
        frameid_b = 8'h5A; ff_data_b = 4'hC;
        tick();
        ff_en_b = 1'b0; start_b = 1'b0;
        check("b_valid", 64'(rd_valid_b), 64'd1);
        check("b_id", 64'(rd_data_b[7:0]), 64'(id_exp_b));
        check("b_frame", 64'(rd_data_b), 64'({8'hC3, id_exp_b}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
